// File: rtl/slc3_datapath_gen.sv
// SLC-3 datapath with configurable width: register file, PC/IR/MAR/MDR,
// ALU, address adder, gated internal bus, condition codes, BEN and LED.
// MDR memory loads wait for MEM_RDY. Handshake: a memory load is requested
// when LD_MDR=1 and MIO_EN=1 in IDLE; the data is taken on the first edge
// where MEM_RDY=1. MDR_BUSY=1 means the request is still outstanding and
// the controller must hold off.
// Bus conflicts (more than one gate) are latched in BUS_ERR until Reset.
module slc3_datapath_gen #(
   parameter int           W        = 16,
   parameter int           LEDW     = 12,
   parameter logic [W-1:0] PC_RESET = '0
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            LD_MAR,
   input  logic            LD_MDR,
   input  logic            LD_IR,
   input  logic            LD_BEN,
   input  logic            LD_CC,
   input  logic            LD_REG,
   input  logic            LD_PC,
   input  logic            LD_LED,
   input  logic            GatePC,
   input  logic            GateMDR,
   input  logic            GateALU,
   input  logic            GateMARMUX,
   input  logic            SR2MUX,
   input  logic            ADDR1MUX,
   input  logic            MARMUX,
   input  logic            DRMUX,
   input  logic            SR1MUX,
   input  logic            MIO_EN,
   input  logic [1:0]      PCMUX,
   input  logic [1:0]      ADDR2MUX,
   input  logic [1:0]      ALUK,
   input  logic [W-1:0]    MDR_In,
   input  logic            MEM_RDY,
   output logic [W-1:0]    MAR,
   output logic [W-1:0]    MDR,
   output logic [W-1:0]    PC,
   output logic [W-1:0]    IR,
   output logic [LEDW-1:0] LED,
   output logic            BEN,
   output logic [2:0]      CC,
   output logic            MDR_BUSY,
   output logic            BUS_ERR
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } mdr_state_t;

   logic [W-1:0]    r_mar;
   logic [W-1:0]    r_mdr;
   logic [W-1:0]    r_pc;
   logic [W-1:0]    r_ir;
   logic [LEDW-1:0] r_led;
   logic            r_ben;
   logic [2:0]      r_cc;
   logic            r_bus_err;
   logic [W-1:0]    r_regs [8];
   mdr_state_t      r_state;
   mdr_state_t      w_next_state;

   logic [2:0]      w_sr1_sel;
   logic [2:0]      w_dr_sel;
   logic [W-1:0]    w_sr1;
   logic [W-1:0]    w_sr2;
   logic [W-1:0]    w_alu_b;
   logic [W-1:0]    w_alu;
   logic [W-1:0]    w_addr1;
   logic [W-1:0]    w_addr2;
   logic [W-1:0]    w_addr;
   logic [W-1:0]    w_marmux;
   logic [W-1:0]    w_pc_next;
   logic [W-1:0]    w_bus;
   logic [2:0]      w_gate_cnt;
   logic            w_conflict;
   logic            w_mdr_ld_bus;
   logic            w_mdr_ld_mem;

   // Register-file addressing and combinational reads (no write forwarding).
   assign w_sr1_sel = SR1MUX ? r_ir[8:6] : r_ir[11:9];
   assign w_dr_sel  = DRMUX  ? 3'd7      : r_ir[11:9];
   assign w_sr1     = r_regs[w_sr1_sel];
   assign w_sr2     = r_regs[r_ir[2:0]];

   // ALU operand B select and operation.
   assign w_alu_b = SR2MUX ? {{(W-5){r_ir[4]}}, r_ir[4:0]} : w_sr2;
   always_comb begin
      w_alu = w_sr1;
      case (ALUK)
         2'b00:   w_alu = w_sr1 + w_alu_b;
         2'b01:   w_alu = w_sr1 & w_alu_b;
         2'b10:   w_alu = ~w_sr1;
         default: w_alu = w_sr1;
      endcase
   end

   // Address adder operands and MARMUX.
   assign w_addr1 = ADDR1MUX ? w_sr1 : r_pc;
   always_comb begin
      w_addr2 = '0;
      case (ADDR2MUX)
         2'b00:   w_addr2 = '0;
         2'b01:   w_addr2 = {{(W-6){r_ir[5]}},  r_ir[5:0]};
         2'b10:   w_addr2 = {{(W-9){r_ir[8]}},  r_ir[8:0]};
         default: w_addr2 = {{(W-11){r_ir[10]}}, r_ir[10:0]};
      endcase
   end
   assign w_addr   = w_addr1 + w_addr2;
   assign w_marmux = MARMUX ? {{(W-8){1'b0}}, r_ir[7:0]} : w_addr;

   // Bus: the single gated source, or zero when idle or in conflict.
   assign w_gate_cnt = {2'b00, GatePC} + {2'b00, GateMDR}
                     + {2'b00, GateALU} + {2'b00, GateMARMUX};
   assign w_conflict = (w_gate_cnt > 3'd1);
   always_comb begin
      w_bus = '0;
      if (!w_conflict) begin
         if (GatePC)          w_bus = r_pc;
         else if (GateMDR)    w_bus = r_mdr;
         else if (GateALU)    w_bus = w_alu;
         else if (GateMARMUX) w_bus = w_marmux;
      end
   end

   // PC source select; PC+1 wraps naturally at W bits.
   always_comb begin
      w_pc_next = r_pc;
      case (PCMUX)
         2'b00:   w_pc_next = r_pc + {{(W-1){1'b0}}, 1'b1};
         2'b01:   w_pc_next = w_bus;
         2'b10:   w_pc_next = w_addr;
         default: w_pc_next = r_pc;
      endcase
   end

   // MDR FSM next state and MDR load decode.
   always_comb begin
      w_next_state = r_state;
      w_mdr_ld_bus = 1'b0;
      w_mdr_ld_mem = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (LD_MDR) begin
               if (!MIO_EN)      w_mdr_ld_bus = 1'b1;
               else if (MEM_RDY) w_mdr_ld_mem = 1'b1;
               else              w_next_state = S_WAIT;
            end
         end
         default: begin
            if (MEM_RDY) begin
               w_mdr_ld_mem = 1'b1;
               w_next_state = S_IDLE;
            end
         end
      endcase
   end

   // MDR FSM state register.
   always_ff @(posedge Clk) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Architectural registers; Reset overrides every load.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_pc      <= PC_RESET;
         r_mar     <= '0;
         r_mdr     <= '0;
         r_ir      <= '0;
         r_led     <= '0;
         r_ben     <= 1'b0;
         r_cc      <= 3'b010;
         r_bus_err <= 1'b0;
      end else begin
         if (LD_PC)        r_pc  <= w_pc_next;
         if (LD_MAR)       r_mar <= w_bus;
         if (w_mdr_ld_bus) r_mdr <= w_bus;
         if (w_mdr_ld_mem) r_mdr <= MDR_In;
         if (LD_IR)        r_ir  <= w_bus;
         if (LD_LED)       r_led <= r_ir[LEDW-1:0];
         if (LD_CC)        r_cc  <= {w_bus[W-1], (w_bus == '0),
                                     (!w_bus[W-1] && (w_bus != '0))};
         // BEN reads the CC register, so a same-cycle CC load is not seen.
         if (LD_BEN)       r_ben <= (r_ir[11] & r_cc[2]) | (r_ir[10] & r_cc[1])
                                  | (r_ir[9] & r_cc[0]);
         if (w_conflict)   r_bus_err <= 1'b1;
      end
   end

   // Register file write port.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      end else if (LD_REG) begin
         r_regs[w_dr_sel] <= w_bus;
      end
   end

   assign MAR      = r_mar;
   assign MDR      = r_mdr;
   assign PC       = r_pc;
   assign IR       = r_ir;
   assign LED      = r_led;
   assign BEN      = r_ben;
   assign CC       = r_cc;
   assign BUS_ERR  = r_bus_err;
   assign MDR_BUSY = (r_state == S_WAIT);

endmodule

// File: tb/tb_slc3_datapath_gen.sv
// Bench for slc3_datapath_gen: a 16-bit and a 32-bit instance share the
// same control stimulus; expected values are queued before each edge and
// popped after it.
module tb_slc3_datapath_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
   logic gate_pc, gate_mdr, gate_alu, gate_marmux;
   logic sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en, mem_rdy;
   logic [1:0]  pcmux, addr2mux, aluk;
   logic [15:0] mdr_in;

   logic [15:0] mar16, mdr16, pc16, ir16;
   logic [11:0] led16;
   logic        ben16, busy16, err16;
   logic [2:0]  cc16;
   logic [31:0] mar32, mdr32, pc32, ir32;
   logic [11:0] led32;
   logic        ben32, busy32, err32;
   logic [2:0]  cc32;

   slc3_datapath_gen #(.W(16), .LEDW(12), .PC_RESET(16'h3000)) dut16 (
      .Clk(clk), .Reset(reset),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
      .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
      .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
      .SR2MUX(sr2mux), .ADDR1MUX(addr1mux), .MARMUX(marmux), .DRMUX(drmux), .SR1MUX(sr1mux),
      .MIO_EN(mio_en), .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
      .MDR_In(mdr_in), .MEM_RDY(mem_rdy),
      .MAR(mar16), .MDR(mdr16), .PC(pc16), .IR(ir16), .LED(led16), .BEN(ben16),
      .CC(cc16), .MDR_BUSY(busy16), .BUS_ERR(err16)
   );

   slc3_datapath_gen #(.W(32), .LEDW(12), .PC_RESET(32'h3000)) dut32 (
      .Clk(clk), .Reset(reset),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
      .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
      .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
      .SR2MUX(sr2mux), .ADDR1MUX(addr1mux), .MARMUX(marmux), .DRMUX(drmux), .SR1MUX(sr1mux),
      .MIO_EN(mio_en), .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
      .MDR_In({16'h0000, mdr_in}), .MEM_RDY(mem_rdy),
      .MAR(mar32), .MDR(mdr32), .PC(pc32), .IR(ir32), .LED(led32), .BEN(ben32),
      .CC(cc32), .MDR_BUSY(busy32), .BUS_ERR(err32)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e16, e32;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctl();
      ld_mar = 0; ld_mdr = 0; ld_ir = 0; ld_ben = 0; ld_cc = 0; ld_reg = 0;
      ld_pc = 0; ld_led = 0; gate_pc = 0; gate_mdr = 0; gate_alu = 0;
      gate_marmux = 0; sr2mux = 0; addr1mux = 0; marmux = 0; drmux = 0;
      sr1mux = 0; mio_en = 0; pcmux = 2'b00; addr2mux = 2'b00; aluk = 2'b00;
   endtask

   task automatic load_mdr_mem(input logic [15:0] v);
      idle_ctl();
      ld_mdr = 1; mio_en = 1; mem_rdy = 1; mdr_in = v;
      step();
      idle_ctl();
      mem_rdy = 0;
   endtask

   task automatic load_ir(input logic [15:0] v);
      load_mdr_mem(v);
      gate_mdr = 1; ld_ir = 1;
      step();
      idle_ctl();
   endtask

   task automatic load_pc(input logic [15:0] v);
      load_mdr_mem(v);
      gate_mdr = 1; ld_pc = 1; pcmux = 2'b01;
      step();
      idle_ctl();
   endtask

   task automatic write_reg(input logic [2:0] r, input logic [15:0] v);
      load_ir({4'b0000, r, 9'b0});
      load_mdr_mem(v);
      gate_mdr = 1; ld_reg = 1;
      step();
      idle_ctl();
   endtask

   // Copies R[r] into MAR through the ALU pass-through.
   task automatic read_reg(input logic [2:0] r);
      load_ir({7'b0, r, 6'b0});
      sr1mux = 1; aluk = 2'b11; gate_alu = 1; ld_mar = 1;
      step();
      idle_ctl();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_ctl();
      reset = 1; mem_rdy = 0; mdr_in = 16'h0;
      exp_q.push_back(32'h3000); exp_q.push_back(32'h3000);
      step();
      step();
      reset = 0;
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (pc16 !== e16[15:0] || pc32 !== e32) begin
         n_errors++; $display("FAIL reset_pc: got %h/%h want %h/%h", pc16, pc32, e16[15:0], e32);
      end
      n_checks++;
      if ({mar16, mdr16, ir16} !== 48'h0 || {mar32, mdr32, ir32} !== 96'h0) begin
         n_errors++; $display("FAIL reset_regs: mar/mdr/ir16=%h %h %h mar/mdr/ir32=%h %h %h want 0",
                              mar16, mdr16, ir16, mar32, mdr32, ir32);
      end
      n_checks++;
      if ({cc16, ben16, err16, busy16, led16} !== {3'b010, 3'b000, 12'h0} ||
          {cc32, ben32, err32, busy32, led32} !== {3'b010, 3'b000, 12'h0}) begin
         n_errors++; $display("FAIL reset_status: cc=%b/%b ben=%b err=%b busy=%b led=%h want cc=010 rest 0",
                              cc16, cc32, ben16, err16, busy16, led16);
      end
      for (int i = 1; i <= 2; i++) begin
         ld_pc = 1; pcmux = 2'b00;
         exp_q.push_back(32'h3000 + i); exp_q.push_back(32'h3000 + i);
         step();
         e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
         if (pc16 !== e16[15:0] || pc32 !== e32) begin
            n_errors++; $display("FAIL pc_incr%0d: got %h/%h want %h/%h", i, pc16, pc32, e16[15:0], e32);
         end
      end
      idle_ctl();
      for (int r = 0; r < 8; r += 7) begin
         exp_q.push_back(32'h0); exp_q.push_back(32'h0);
         read_reg(r[2:0]);
         e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
         if (mar16 !== e16[15:0] || mar32 !== e32) begin
            n_errors++; $display("FAIL reset_r%0d: got %h/%h want %h/%h", r, mar16, mar32, e16[15:0], e32);
         end
      end
   endtask

   task automatic test_pc_wrap();
      load_pc(16'hFFFF);
      ld_pc = 1; pcmux = 2'b00;
      exp_q.push_back(32'h0000); exp_q.push_back(32'h0001_0000);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (pc16 !== e16[15:0] || pc32 !== e32) begin
         n_errors++; $display("FAIL pc_wrap: got %h/%h want %h/%h", pc16, pc32, e16[15:0], e32);
      end
   endtask

   task automatic test_add();
      logic [15:0] irs [2];
      logic [31:0] res [2];
      logic [2:0]  ccs [2];
      irs[0] = 16'h047D; res[0] = 32'h2; ccs[0] = 3'b001;
      irs[1] = 16'h047B; res[1] = 32'h0; ccs[1] = 3'b010;
      for (int k = 0; k < 2; k++) begin
         write_reg(3'd1, 16'h0005);
         load_ir(irs[k]);
         sr1mux = 1; sr2mux = 1; aluk = 2'b00; gate_alu = 1; ld_reg = 1; ld_cc = 1;
         exp_q.push_back({29'h0, ccs[k]}); exp_q.push_back({29'h0, ccs[k]});
         step();
         idle_ctl();
         e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
         if (cc16 !== e16[2:0] || cc32 !== e32[2:0]) begin
            n_errors++; $display("FAIL add_cc%0d: got %b/%b want %b", k, cc16, cc32, e16[2:0]);
         end
         exp_q.push_back(res[k]); exp_q.push_back(res[k]);
         read_reg(3'd2);
         e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
         if (mar16 !== e16[15:0] || mar32 !== e32) begin
            n_errors++; $display("FAIL add_r2_%0d: got %h/%h want %h/%h", k, mar16, mar32, e16[15:0], e32);
         end
      end
   endtask

   task automatic test_alu_logic();
      write_reg(3'd1, 16'h00F5);
      write_reg(3'd4, 16'h0F0F);
      load_ir(16'h0A44);
      sr1mux = 1; sr2mux = 0; aluk = 2'b01; gate_alu = 1; ld_reg = 1; ld_cc = 1;
      step();
      idle_ctl();
      load_ir(16'h0A44);
      sr1mux = 1; aluk = 2'b10; gate_alu = 1; ld_reg = 1; ld_cc = 1; drmux = 1;
      exp_q.push_back(32'b100); exp_q.push_back(32'b100);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (cc16 !== e16[2:0] || cc32 !== e32[2:0]) begin
         n_errors++; $display("FAIL not_cc: got %b/%b want %b", cc16, cc32, e16[2:0]);
      end
      exp_q.push_back(32'h0005); exp_q.push_back(32'h0005);
      read_reg(3'd5);
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (mar16 !== e16[15:0] || mar32 !== e32) begin
         n_errors++; $display("FAIL and_r5: got %h/%h want %h/%h", mar16, mar32, e16[15:0], e32);
      end
      exp_q.push_back(32'hFF0A); exp_q.push_back(32'hFFFF_FF0A);
      read_reg(3'd7);
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (mar16 !== e16[15:0] || mar32 !== e32) begin
         n_errors++; $display("FAIL not_r7: got %h/%h want %h/%h", mar16, mar32, e16[15:0], e32);
      end
   endtask

   task automatic test_branch();
      load_ir(16'h0800);
      load_mdr_mem(16'h8000);
      gate_mdr = 1; ld_cc = 1;
      exp_q.push_back(32'b100); exp_q.push_back(32'b001);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (cc16 !== e16[2:0] || cc32 !== e32[2:0]) begin
         n_errors++; $display("FAIL br_cc: got %b/%b want %b/%b", cc16, cc32, e16[2:0], e32[2:0]);
      end
      ld_ben = 1;
      exp_q.push_back(32'h1); exp_q.push_back(32'h0);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (ben16 !== e16[0] || ben32 !== e32[0]) begin
         n_errors++; $display("FAIL ben_n: got %b/%b want %b/%b", ben16, ben32, e16[0], e32[0]);
      end
      load_ir(16'h0400);
      // Bus idle (zero) while CC and BEN load together: BEN sees the old CC.
      ld_cc = 1; ld_ben = 1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (ben16 !== e16[0] || ben32 !== e32[0] || cc16 !== 3'b010) begin
         n_errors++; $display("FAIL ben_old_cc: got ben %b/%b cc %b want ben 0/0 cc 010", ben16, ben32, cc16);
      end
      ld_ben = 1;
      exp_q.push_back(32'h1); exp_q.push_back(32'h1);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (ben16 !== e16[0] || ben32 !== e32[0]) begin
         n_errors++; $display("FAIL ben_z: got %b/%b want %b/%b", ben16, ben32, e16[0], e32[0]);
      end
   endtask

   task automatic test_addr();
      logic [1:0]  a2 [4];
      logic        a1 [4];
      logic        mm [4];
      logic [31:0] x16 [4];
      logic [31:0] x32 [4];
      load_pc(16'h3000);
      load_ir(16'h01FF);
      a2[0] = 2'b10; a1[0] = 0; mm[0] = 0; x16[0] = 32'h2FFF; x32[0] = 32'h2FFF;
      a2[1] = 2'b01; a1[1] = 0; mm[1] = 0; x16[1] = 32'h2FFF; x32[1] = 32'h2FFF;
      a2[2] = 2'b11; a1[2] = 1; mm[2] = 0; x16[2] = 32'h0109; x32[2] = 32'h0109;
      a2[3] = 2'b00; a1[3] = 0; mm[3] = 1; x16[3] = 32'h00FF; x32[3] = 32'h00FF;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin
            // PC <- ADDR (2FFF), then hold.
            addr2mux = 2'b10; ld_pc = 1; pcmux = 2'b10;
            step();
            idle_ctl();
            ld_pc = 1; pcmux = 2'b11;
            exp_q.push_back(32'h2FFF); exp_q.push_back(32'h2FFF);
            step();
            idle_ctl();
            e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
            if (pc16 !== e16[15:0] || pc32 !== e32) begin
               n_errors++; $display("FAIL pc_addr_hold: got %h/%h want %h/%h", pc16, pc32, e16[15:0], e32);
            end
            // ADDR2MUX=01 now gives PC + (-1).
            x16[1] = 32'h2FFE; x32[1] = 32'h2FFE;
         end
         addr2mux = a2[k]; addr1mux = a1[k]; sr1mux = 1; marmux = mm[k];
         gate_marmux = 1; ld_mar = 1;
         exp_q.push_back(x16[k]); exp_q.push_back(x32[k]);
         step();
         idle_ctl();
         e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
         if (mar16 !== e16[15:0] || mar32 !== e32) begin
            n_errors++; $display("FAIL marmux%0d: got %h/%h want %h/%h", k, mar16, mar32, e16[15:0], e32);
         end
      end
      ld_led = 1;
      exp_q.push_back(32'h1FF); exp_q.push_back(32'h1FF);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (led16 !== e16[11:0] || led32 !== e32[11:0]) begin
         n_errors++; $display("FAIL led: got %h/%h want %h", led16, led32, e16[11:0]);
      end
   endtask

   task automatic test_mem();
      load_pc(16'h1234);
      ld_pc = 1; pcmux = 2'b00;
      step();
      idle_ctl();
      gate_pc = 1; ld_mdr = 1; mio_en = 0;
      exp_q.push_back(32'h1235); exp_q.push_back(32'h1235);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (mdr16 !== e16[15:0] || mdr32 !== e32) begin
         n_errors++; $display("FAIL mdr_bus: got %h/%h want %h/%h", mdr16, mdr32, e16[15:0], e32);
      end
      // Request with MEM_RDY low, two more low cycles (LD_MDR from bus ignored).
      for (int c = 0; c < 3; c++) begin
         ld_mdr = 1; mio_en = (c == 0); gate_pc = (c != 0); mem_rdy = 0; mdr_in = 16'hAAAA;
         exp_q.push_back({15'h0, 1'b1, 16'h1235}); exp_q.push_back({15'h0, 1'b1, 16'h1235});
         step();
         idle_ctl();
         e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
         if ({busy16, mdr16} !== e16[16:0] || {busy32, mdr32[15:0]} !== e32[16:0]) begin
            n_errors++; $display("FAIL wait%0d: busy=%b/%b mdr=%h/%h want busy=1 mdr=1235",
                                 c, busy16, busy32, mdr16, mdr32);
         end
      end
      mem_rdy = 1; mdr_in = 16'hBEEF;
      exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF);
      step();
      mem_rdy = 0;
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (busy16 !== 1'b0 || busy32 !== 1'b0 || mdr16 !== e16[15:0] || mdr32 !== e32) begin
         n_errors++; $display("FAIL mem_done: busy=%b/%b mdr=%h/%h want 0 %h", busy16, busy32, mdr16, mdr32, e16[15:0]);
      end
      // Reset while waiting drops the pending response.
      ld_mdr = 1; mio_en = 1;
      step();
      idle_ctl();
      reset = 1; mem_rdy = 1; mdr_in = 16'h5555;
      exp_q.push_back(32'h3000); exp_q.push_back(32'h3000);
      step();
      reset = 0;
      step();
      mem_rdy = 0;
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (busy16 !== 1'b0 || busy32 !== 1'b0 || mdr16 !== 16'h0 || mdr32 !== 32'h0 ||
          pc16 !== e16[15:0] || pc32 !== e32) begin
         n_errors++; $display("FAIL reset_in_wait: busy=%b/%b mdr=%h/%h pc=%h want 0 0000 %h",
                              busy16, busy32, mdr16, mdr32, pc16, e16[15:0]);
      end
   endtask

   task automatic test_bus_conflict();
      gate_pc = 1; ld_mar = 1;
      step();
      gate_alu = 1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      step();
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (mar16 !== e16[15:0] || mar32 !== e32 || err16 !== 1'b1 || err32 !== 1'b1) begin
         n_errors++; $display("FAIL conflict: mar=%h/%h err=%b/%b want 0 1", mar16, mar32, err16, err32);
      end
      exp_q.push_back(32'h1); exp_q.push_back(32'h1);
      for (int c = 0; c < 10; c++) begin
         gate_pc = 1; ld_pc = 1; pcmux = 2'b00;
         step();
      end
      idle_ctl();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (err16 !== e16[0] || err32 !== e32[0]) begin
         n_errors++; $display("FAIL sticky: got %b/%b want 1", err16, err32);
      end
      // Reset clears the flag even while two gates are high.
      reset = 1; gate_pc = 1; gate_mdr = 1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      step();
      reset = 0; idle_ctl();
      step();
      e16 = exp_q.pop_front(); e32 = exp_q.pop_front(); n_checks++;
      if (err16 !== e16[0] || err32 !== e32[0]) begin
         n_errors++; $display("FAIL reset_conflict: got %b/%b want 0", err16, err32);
      end
   endtask

   initial begin
      reset = 1; mem_rdy = 0; mdr_in = 16'h0;
      idle_ctl();
      test_reset();
      test_pc_wrap();
      test_add();
      test_alu_logic();
      test_branch();
      test_addr();
      test_mem();
      test_bus_conflict();
      if (exp_q.size() != 0) begin
         n_errors++; $display("FAIL scoreboard: %0d expected entries left", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
